// File: rtl/simple_io_pkg.sv
// Shared types and defaults for the simple IN/OUT responder.
package simple_io_pkg;

  localparam int unsigned DefaultDataW = 16;

  // IN request sequencing.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StAck  = 2'd2
  } in_state_e;

endpackage

// File: rtl/simple_io_responder_if.sv
// CPU strobe and host handshake signals of the IN/OUT responder.
interface simple_io_responder_if
  import simple_io_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) ();

  logic              cpu_out_req;
  logic [DATA_W-1:0] cpu_out_data;
  logic              cpu_in_req;
  logic [DATA_W-1:0] cpu_in_data;
  logic              cpu_in_ack;
  logic              cpu_stall;
  logic              host_out_valid;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_ready;
  logic              host_in_valid;
  logic [DATA_W-1:0] host_in_data;
  logic              host_in_ready;

  // CPU core plus board host driving the responder.
  modport master (
    output cpu_out_req, cpu_out_data, cpu_in_req, host_out_ready, host_in_valid, host_in_data,
    input  cpu_in_data, cpu_in_ack, cpu_stall, host_out_valid, host_out_data, host_in_ready
  );

  // The responder itself.
  modport slave (
    input  cpu_out_req, cpu_out_data, cpu_in_req, host_out_ready, host_in_valid, host_in_data,
    output cpu_in_data, cpu_in_ack, cpu_stall, host_out_valid, host_out_data, host_in_ready
  );

endinterface

// File: rtl/io_fifo.sv
// Synchronous first-word-fall-through FIFO; head is read straight from storage.
module io_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PTR_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FullCount = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] PtrOne    = (PTR_W+1)'(1);

  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  // Occupancy from wrap-bit pointers; a push into a full FIFO is legal when a pop frees a slot.
  always_comb begin
    count   = wr_ptr_q - rd_ptr_q;
    full    = (count == FullCount);
    empty   = (count == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    head    = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  // Pointer and storage update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        wr_ptr_q                   <= wr_ptr_q + PtrOne;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

endmodule

// File: rtl/simple_io_responder.sv
// Device-side responder for CPU IN/OUT: OUT words queue to the host, IN words come from
// a one-entry hold register.
module simple_io_responder
  import simple_io_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PTR_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  simple_io_responder_if.slave  bus,
  output logic [PTR_W:0]        out_count,
  output logic                  ovf_err
);

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_push_data, fifo_head;

  logic              pend_q, pend_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              ovf_q, ovf_d;
  logic              out_stall;

  in_state_e         state_q, state_d;
  logic              in_block_q, in_block_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              in_stall, in_ack, in_ready;

  io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (out_count)
  );

  assign fifo_pop = ~fifo_empty & bus.host_out_ready;

  // OUT path: a word arriving at a full FIFO parks in the pending register until a pop.
  always_comb begin
    pend_d         = pend_q;
    pend_data_d    = pend_data_q;
    ovf_d          = ovf_q;
    fifo_push      = 1'b0;
    fifo_push_data = bus.cpu_out_data;
    out_stall      = 1'b0;
    if (pend_q) begin
      fifo_push_data = pend_data_q;
      if (fifo_pop) begin
        fifo_push = 1'b1;
        pend_d    = 1'b0;
      end else begin
        out_stall = 1'b1;
      end
      // The pending slot is taken, so any further OUT is lost.
      if (bus.cpu_out_req) begin
        ovf_d = 1'b1;
      end
    end else if (bus.cpu_out_req) begin
      if (!fifo_full || fifo_pop) begin
        fifo_push = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_data_d = bus.cpu_out_data;
        out_stall   = 1'b1;
      end
    end
  end

  // IN FSM next state; in_block keeps a still-held request from re-triggering after its ack.
  always_comb begin
    state_d    = state_q;
    in_block_d = in_block_q & bus.cpu_in_req;
    in_stall   = 1'b0;
    in_ack     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_in_req && !in_block_q) begin
          state_d = hold_full_q ? StAck : StWait;
        end
      end
      StWait: begin
        in_stall = 1'b1;
        // A word loading this cycle is readable in the next (ACK) cycle.
        if (hold_full_q || bus.host_in_valid) begin
          state_d = StAck;
        end
      end
      StAck: begin
        in_ack     = 1'b1;
        state_d    = StIdle;
        in_block_d = bus.cpu_in_req;
      end
      default: state_d = StIdle;
    endcase
  end

  // Hold register: empties on ack, and may reload from the host in that same cycle.
  always_comb begin
    in_ready    = ~hold_full_q | in_ack;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    if (in_ack) begin
      hold_full_d = 1'b0;
    end
    if (bus.host_in_valid && in_ready) begin
      hold_full_d = 1'b1;
      hold_d      = bus.host_in_data;
    end
  end

  // All responder state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      ovf_q       <= 1'b0;
      state_q     <= StIdle;
      in_block_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      in_block_q  <= in_block_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.cpu_in_data    = in_ack ? hold_q : '0;
  assign bus.cpu_in_ack     = in_ack;
  assign bus.cpu_stall      = out_stall | in_stall;
  assign bus.host_out_valid = ~fifo_empty;
  assign bus.host_out_data  = fifo_head;
  assign bus.host_in_ready  = in_ready;
  assign ovf_err            = ovf_q;

endmodule

// File: tb/tb_simple_io_responder.sv
// Directed self-checking bench for simple_io_responder. Inputs change on the falling edge,
// outputs are compared on the falling edge (plus 1 time unit for combinational paths).
module tb_simple_io_responder;

  localparam int unsigned DataW = 16;
  localparam int unsigned Depth = 8;
  localparam int unsigned PtrW  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [PtrW:0]   out_count;
  logic            ovf_err;

  int checks   = 0;
  int failures = 0;

  logic [DataW-1:0] exp_q [9];

  simple_io_responder_if #(.DATA_W(DataW)) bus ();

  simple_io_responder #(
    .DATA_W (DataW),
    .DEPTH  (Depth),
    .PTR_W  (PtrW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .out_count (out_count),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    bus.cpu_out_req    = 1'b0;
    bus.cpu_out_data   = '0;
    bus.cpu_in_req     = 1'b0;
    bus.host_out_ready = 1'b0;
    bus.host_in_valid  = 1'b0;
    bus.host_in_data   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset values
    check("rst_count", 32'(out_count), 0);
    check("rst_out_valid", 32'(bus.host_out_valid), 0);
    check("rst_out_data", 32'(bus.host_out_data), 0);
    check("rst_in_ready", 32'(bus.host_in_ready), 1);
    check("rst_in_ack", 32'(bus.cpu_in_ack), 0);
    check("rst_in_data", 32'(bus.cpu_in_data), 0);
    check("rst_stall", 32'(bus.cpu_stall), 0);
    check("rst_ovf", 32'(ovf_err), 0);

    // OUT ordering: fill with 1..8 while the host is not ready
    tick();
    for (int i = 1; i <= 8; i++) begin
      bus.cpu_out_req  = 1'b1;
      bus.cpu_out_data = 16'(i);
      #1;
      check("ord_no_stall", 32'(bus.cpu_stall), 0);
      tick();
    end
    bus.cpu_out_req = 1'b0;
    #1;
    check("ord_count8", 32'(out_count), 8);
    check("ord_valid", 32'(bus.host_out_valid), 1);
    bus.host_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      check("ord_data", 32'(bus.host_out_data), 32'(i));
      tick();
    end
    bus.host_out_ready = 1'b0;
    #1;
    check("ord_count0", 32'(out_count), 0);
    check("ord_empty", 32'(bus.host_out_valid), 0);

    // Full stall, pending word, overflow
    for (int i = 0; i < 8; i++) begin
      bus.cpu_out_req  = 1'b1;
      bus.cpu_out_data = 16'(16 + i);
      exp_q[i]         = 16'(16 + i);
      tick();
    end
    exp_q[8]         = 16'hBEEF;
    bus.cpu_out_data = 16'hBEEF;
    #1;
    check("full_stall_same_cycle", 32'(bus.cpu_stall), 1);
    tick();
    bus.cpu_out_req = 1'b0;
    #1;
    check("full_stall_pending", 32'(bus.cpu_stall), 1);
    check("full_count", 32'(out_count), 8);
    check("full_ovf_clear", 32'(ovf_err), 0);
    bus.cpu_out_req  = 1'b1;
    bus.cpu_out_data = 16'hDEAD;
    tick();
    bus.cpu_out_req = 1'b0;
    #1;
    check("full_ovf_set", 32'(ovf_err), 1);
    check("full_stall_held", 32'(bus.cpu_stall), 1);
    bus.host_out_ready = 1'b1;
    #1;
    check("full_stall_drop_on_pop", 32'(bus.cpu_stall), 0);
    for (int k = 0; k < 9; k++) begin
      check("full_drain_data", 32'(bus.host_out_data), 32'(exp_q[k]));
      tick();
      #1;
    end
    bus.host_out_ready = 1'b0;
    #1;
    check("full_drain_count", 32'(out_count), 0);
    check("full_ovf_sticky", 32'(ovf_err), 1);

    // IN with data already held
    tick();
    bus.host_in_valid = 1'b1;
    bus.host_in_data  = 16'h1234;
    tick();
    bus.host_in_valid = 1'b0;
    #1;
    check("in_hold_full", 32'(bus.host_in_ready), 0);
    bus.cpu_in_req = 1'b1;
    #1;
    check("in_no_stall_req", 32'(bus.cpu_stall), 0);
    tick();
    #1;
    check("in_ack", 32'(bus.cpu_in_ack), 1);
    check("in_data", 32'(bus.cpu_in_data), 32'h1234);
    check("in_no_stall_ack", 32'(bus.cpu_stall), 0);
    // Request still held one cycle past the ack must not start a new transfer
    tick();
    #1;
    check("in_no_reenter_ack", 32'(bus.cpu_in_ack), 0);
    check("in_no_reenter_stall", 32'(bus.cpu_stall), 0);
    check("in_hold_empty", 32'(bus.host_in_ready), 1);
    bus.cpu_in_req = 1'b0;
    tick();

    // IN before data: stall until the host offers a word five cycles later
    bus.cpu_in_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      check("wait_stall", 32'(bus.cpu_stall), 1);
      check("wait_no_ack", 32'(bus.cpu_in_ack), 0);
    end
    bus.host_in_valid = 1'b1;
    bus.host_in_data  = 16'hA5A5;
    tick();
    bus.host_in_valid = 1'b0;
    #1;
    check("wait_ack", 32'(bus.cpu_in_ack), 1);
    check("wait_data", 32'(bus.cpu_in_data), 32'hA5A5);
    check("wait_stall_drop", 32'(bus.cpu_stall), 0);
    bus.cpu_in_req = 1'b0;
    tick();
    #1;
    check("wait_ack_pulse", 32'(bus.cpu_in_ack), 0);

    // Simultaneous push and pop at count=1
    bus.cpu_out_req  = 1'b1;
    bus.cpu_out_data = 16'h0100;
    tick();
    bus.cpu_out_data   = 16'h0200;
    bus.host_out_ready = 1'b1;
    #1;
    check("pp_old_head", 32'(bus.host_out_data), 32'h0100);
    tick();
    bus.cpu_out_req    = 1'b0;
    bus.host_out_ready = 1'b0;
    #1;
    check("pp_count", 32'(out_count), 1);
    check("pp_new_head", 32'(bus.host_out_data), 32'h0200);

    // Host load in the ACK cycle keeps the new word
    bus.host_in_valid = 1'b1;
    bus.host_in_data  = 16'h1111;
    tick();
    bus.host_in_valid = 1'b0;
    bus.cpu_in_req    = 1'b1;
    tick();
    #1;
    check("ackload_ack", 32'(bus.cpu_in_ack), 1);
    check("ackload_data1", 32'(bus.cpu_in_data), 32'h1111);
    check("ackload_ready", 32'(bus.host_in_ready), 1);
    bus.host_in_valid = 1'b1;
    bus.host_in_data  = 16'h2222;
    bus.cpu_in_req    = 1'b0;
    tick();
    bus.host_in_valid = 1'b0;
    #1;
    check("ackload_held", 32'(bus.host_in_ready), 0);
    bus.cpu_in_req = 1'b1;
    tick();
    #1;
    check("ackload_ack2", 32'(bus.cpu_in_ack), 1);
    check("ackload_data2", 32'(bus.cpu_in_data), 32'h2222);
    bus.cpu_in_req = 1'b0;

    // Asynchronous reset mid-stream at count=3 with a held IN word
    bus.cpu_out_req   = 1'b1;
    bus.cpu_out_data  = 16'h0300;
    bus.host_in_valid = 1'b1;
    bus.host_in_data  = 16'h7777;
    tick();
    bus.cpu_out_data  = 16'h0400;
    bus.host_in_valid = 1'b0;
    tick();
    bus.cpu_out_req = 1'b0;
    #1;
    check("mid_count3", 32'(out_count), 3);
    check("mid_hold_full", 32'(bus.host_in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(out_count), 0);
    check("arst_out_valid", 32'(bus.host_out_valid), 0);
    check("arst_in_ready", 32'(bus.host_in_ready), 1);
    check("arst_stall", 32'(bus.cpu_stall), 0);
    check("arst_ovf", 32'(ovf_err), 0);
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    check("post_rst_count", 32'(out_count), 0);
    check("post_rst_ack", 32'(bus.cpu_in_ack), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_io_responder.md
Name: simple_io_responder

Overview:
- Device-side responder for the processor's IN/OUT instructions: accepts OUT words from the CPU and supplies IN words to it.
- OUT words are buffered in a FIFO and drained by an external host through a valid/ready handshake.
- IN words come from the host through a one-entry holding register and are returned to the CPU with an acknowledge.
- Sits between the CPU core's Input/Output control strobes and the board-level host/switch interface; asserts a stall when a request cannot complete.

Parameters:
- DATA_W, 16, width of every data word
- DEPTH, 8, output FIFO depth in words; power of two, at least 2
- PTR_W, 3, log2(DEPTH)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- cpu_out_req  in  1  one-cycle pulse, CPU executing OUT
- cpu_out_data  in  DATA_W  word to output; valid with cpu_out_req
- cpu_in_req  in  1  level, CPU executing IN; held until cpu_in_ack
- cpu_in_data  out  DATA_W  word returned to CPU; valid when cpu_in_ack=1
- cpu_in_ack  out  1  one-cycle pulse, IN complete
- cpu_stall  out  1  CPU must hold its phase counter
- host_out_valid  out  1  FIFO head available
- host_out_data  out  DATA_W  FIFO head word
- host_out_ready  in  1  host consumes head when valid&ready
- host_in_valid  in  1  host offers an input word
- host_in_data  in  DATA_W  offered word
- host_in_ready  out  1  holding register empty
- out_count  out  PTR_W+1  FIFO occupancy, 0..DEPTH
- ovf_err  out  1  sticky: OUT dropped while full and stalled past limit

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n, asynchronous, active-low. All state is cleared on rst_n=0 regardless of clk.
- Reset values: FIFO empty, out_count=0, host_out_valid=0, host_out_data=0, hold register empty, host_in_ready=1, cpu_in_data=0, cpu_in_ack=0, cpu_stall=0, ovf_err=0, FSM=IDLE.
- OUT path, FIFO not full: cpu_out_req writes cpu_out_data at the tail on that edge. out_count increments next cycle. cpu_stall stays 0.
- OUT path, FIFO full: cpu_stall is asserted combinationally in the same cycle as cpu_out_req.
  - The word is captured into an internal pending register.
  - The pending word enters the FIFO on the first cycle a pop occurs; cpu_stall drops in that cycle.
  - If a second cpu_out_req arrives while pending, set ovf_err and drop the new word.
- Pop: host_out_valid & host_out_ready removes the head. host_out_data shows the new head next cycle (first-word-fall-through; registered output).
- Simultaneous push and pop: count unchanged; when count=1, the pushed word becomes the head.
- Pointers wrap modulo DEPTH. Full is defined as count==DEPTH; pointers carry an extra wrap bit.
- IN FSM states: IDLE, WAIT, ACK.
  - IDLE: on cpu_in_req, if the hold register is full, go to ACK; otherwise go to WAIT with cpu_stall=1.
  - WAIT: cpu_stall=1 until the hold register fills, then go to ACK.
  - ACK: drive cpu_in_data=hold, cpu_in_ack=1 for exactly one cycle. The hold register empties and the FSM returns to IDLE. The FSM does not re-enter until cpu_in_req deasserts for at least one cycle.
- IN latency: 1 cycle if a word is already held; otherwise arrival cycle + 1.
- Hold register loads when host_in_valid & host_in_ready. host_in_ready=0 while full.
  - In the ACK cycle the register empties; a new load in that same cycle is allowed and takes the new word.
- cpu_stall = OUT-pending OR FSM in WAIT.
- Simultaneous cpu_out_req and cpu_in_req: both are serviced independently.
- Reset asserted mid-operation: the pending OUT word and the held IN word are lost; no ack is generated.

Decomposition:
- Shared package simple_io_pkg:
  - DATA_W default
  - IN FSM state enum (IDLE=2'd0, WAIT=2'd1, ACK=2'd2)
- Sub-module io_fifo (parameterized DEPTH/DATA_W synchronous FWFT FIFO):
  - push, pop, full, empty, count
  - holds the pointer and wrap logic.
- The responder holds the pending-OUT register, the hold register, the IN FSM and the stall/error logic.

Test Plan:
- Reset: hold rst_n=0 mid-stream with FIFO count=3 -> count=0, host_out_valid=0, host_in_ready=1, cpu_stall=0 immediately, asynchronously.
- OUT ordering: 8 OUT pulses with data 0x0001..0x0008, host_out_ready=0 -> count=8, no stall. Then ready=1 -> host sees 0x0001..0x0008 in order over 8 cycles.
- Full stall: FIFO full, OUT 0xBEEF -> cpu_stall=1 same cycle. One pop later -> stall=0, 0xBEEF is the last word read. A second OUT while stalled -> ovf_err=1.
- IN with data present: host loads 0x1234, then cpu_in_req -> cpu_in_ack one cycle later with cpu_in_data=0x1234, cpu_stall never asserted.
- IN before data: cpu_in_req with hold empty -> stall=1. Host offers 0xA5A5 five cycles later -> ack on next cycle, data 0xA5A5, stall drops.
- Concurrency: simultaneous push/pop at count=1, plus host load in the ACK cycle -> count stays 1, new head correct, hold register keeps the new word.
